// File: rtl/tiny_bcd.sv
// Registered binary-to-7-segment hex decoder with lamp test, blanking and load enable.
// Optional ripple-zero blanking (rbi_n/rbo_n) is built when TINY_BCD_RBZ_EN is defined.
module tiny_bcd (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic en,
  input  logic lt_n,
  input  logic bi_n,
`ifdef TINY_BCD_RBZ_EN
  input  logic rbi_n,
  output logic rbo_n,
`endif
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Qe,
  output logic Qf,
  output logic Qg
);

  // Unknown codes fall through to the default arm, so X never reaches the segments.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h72;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      4'hF:    seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

`ifdef TINY_BCD_RBZ_EN
  function automatic logic code_is_zero(input logic [3:0] code);
    logic zero;
    case (code)
      4'h0:    zero = 1'b1;
      default: zero = 1'b0;
    endcase
    return zero;
  endfunction
`endif

  logic [3:0] code_s;
  logic [6:0] seg_next_s;
  logic [6:0] seg_r;
  logic       rbo_next_s;
  logic       rbo_r;

  assign code_s = {D, C, B, A};

  // Next segment pattern: blank beats lamp test, lamp test beats zero blanking and the table.
  always_comb begin
    seg_next_s = 7'h00;
    rbo_next_s = 1'b1;
    if (!bi_n) begin
      seg_next_s = 7'h00;
    end else if (!lt_n) begin
      seg_next_s = 7'h7F;
    end else begin
`ifdef TINY_BCD_RBZ_EN
      if (!rbi_n && code_is_zero(code_s)) begin
        seg_next_s = 7'h00;
        rbo_next_s = 1'b0;
      end else begin
        seg_next_s = seg_decode(code_s);
      end
`else
      seg_next_s = seg_decode(code_s);
`endif
    end
  end

  // Output register: loads only when en is high, clears to blank on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'h00;
      rbo_r <= 1'b1;
    end else if (en) begin
      seg_r <= seg_next_s;
      rbo_r <= rbo_next_s;
    end else begin
      seg_r <= seg_r;
      rbo_r <= rbo_r;
    end
  end

  assign {Qa, Qb, Qc, Qd, Qe, Qf, Qg} = seg_r;

`ifdef TINY_BCD_RBZ_EN
  assign rbo_n = rbo_r;
`else
  logic unused_rbo_s;
  assign unused_rbo_s = rbo_r ^ rbo_next_s;
`endif

endmodule

// File: tb/tb_tiny_bcd.sv
// Directed self-checking bench for tiny_bcd; covers the RBZ ports when TINY_BCD_RBZ_EN is defined.
module tb_tiny_bcd;

  logic clk;
  logic rst_n;
  logic A, B, C, D;
  logic en, lt_n, bi_n;
  logic Qa, Qb, Qc, Qd, Qe, Qf, Qg;
`ifdef TINY_BCD_RBZ_EN
  logic rbi_n;
  logic rbo_n;
`endif

  int n_checks;
  int n_pass;

  localparam logic [6:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  tiny_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .en    (en),
    .lt_n  (lt_n),
    .bi_n  (bi_n),
`ifdef TINY_BCD_RBZ_EN
    .rbi_n (rbi_n),
    .rbo_n (rbo_n),
`endif
    .Qa    (Qa),
    .Qb    (Qb),
    .Qc    (Qc),
    .Qd    (Qd),
    .Qe    (Qe),
    .Qf    (Qf),
    .Qg    (Qg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segs();
    return {Qa, Qb, Qc, Qd, Qe, Qf, Qg};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_code(input logic [3:0] code);
    {D, C, B, A} = code;
  endtask

  // Advance one rising edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    lt_n  = 1'b1;
    bi_n  = 1'b1;
    set_code(4'h0);
`ifdef TINY_BCD_RBZ_EN
    rbi_n = 1'b1;
`endif

    // Reset holds the digit blank across clock edges.
    repeat (2) tick();
    check_eq("reset_blank", {1'b0, segs()}, 8'h00);
`ifdef TINY_BCD_RBZ_EN
    check_eq("reset_rbo", {7'h00, rbo_n}, 8'h01);
`endif
    rst_n = 1'b1;
    tick();
    check_eq("first_load_0", {1'b0, segs()}, 8'h7E);

    // Full table sweep, one cycle latency.
    for (int i = 0; i < 16; i++) begin
      set_code(4'(i));
      tick();
      check_eq($sformatf("table_%0h", i), {1'b0, segs()}, {1'b0, GLYPH[i]});
    end

    // Load enable holds the glyph.
    set_code(4'h8);
    tick();
    check_eq("load_8", {1'b0, segs()}, 8'h7F);
    en = 1'b0;
    set_code(4'h1);
    repeat (2) tick();
    check_eq("hold_en0", {1'b0, segs()}, 8'h7F);
    en = 1'b1;
    tick();
    check_eq("resume_1", {1'b0, segs()}, 8'h30);

    // Blanking is gated by en.
    en = 1'b0;
    bi_n = 1'b0;
    tick();
    check_eq("bi_gated", {1'b0, segs()}, 8'h30);
    en = 1'b1;
    bi_n = 1'b1;

    // Lamp test, then blank beats lamp test, then release.
    set_code(4'h4);
    lt_n = 1'b0;
    tick();
    check_eq("lamp_test", {1'b0, segs()}, 8'h7F);
    bi_n = 1'b0;
    tick();
    check_eq("bi_over_lt", {1'b0, segs()}, 8'h00);
    lt_n = 1'b1;
    bi_n = 1'b1;
    tick();
    check_eq("release_4", {1'b0, segs()}, 8'h33);

    // Asynchronous reset mid-cycle.
    set_code(4'h5);
    tick();
    check_eq("show_5", {1'b0, segs()}, 8'h5B);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {1'b0, segs()}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    set_code(4'hD);
    en = 1'b0;
    tick();
    check_eq("post_reset_en0", {1'b0, segs()}, 8'h00);
    en = 1'b1;
    tick();
    check_eq("post_reset_load", {1'b0, segs()}, 8'h3D);

`ifdef TINY_BCD_RBZ_EN
    // Ripple-zero blanking.
    rbi_n = 1'b0;
    set_code(4'h0);
    tick();
    check_eq("rbz_zero", {rbo_n, segs()}, 8'h00);
    set_code(4'h3);
    tick();
    check_eq("rbz_nonzero", {rbo_n, segs()}, 8'hF9);
    set_code(4'h0);
    lt_n = 1'b0;
    tick();
    check_eq("rbz_lt_over", {rbo_n, segs()}, 8'hFF);
    lt_n = 1'b1;
    rbi_n = 1'b1;
    tick();
    check_eq("rbz_off_0", {rbo_n, segs()}, 8'hFE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
